// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op and state encodings plus counter-width helper for the mul/div unit

package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's complement negation

module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit owning HI/LO
// Signed mult/div are compiled in only when MULDIV_SIGNED_EN is defined.

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;       // multiply: {partial product, multiplier}; divide: low half is quotient
    logic [WIDTH:0]       rem;
    logic [WIDTH-1:0]     mcand;     // multiplicand or divisor magnitude
    logic                 is_div_q;
    logic                 b_zero_q;
    logic                 sign_lo_q;
    logic                 sign_hi_q;

    logic                 is_div_op;
    logic                 signed_op;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 q_bit;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic                 unused_bits;

    assign is_div_op = (op == OP_DIVU) || (op == OP_DIV);

`ifdef MULDIV_SIGNED_EN
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = signed_op & a[WIDTH-1];
    assign sign_b    = signed_op & b[WIDTH-1];

    muldiv_negate #(.W(WIDTH))   u_abs_a (.x(a),              .neg(sign_a),    .y(a_mag));
    muldiv_negate #(.W(WIDTH))   u_abs_b (.x(b),              .neg(sign_b),    .y(b_mag));
    muldiv_negate #(.W(2*WIDTH)) u_fix_p (.x(acc),            .neg(sign_lo_q), .y(prod_fix));
    muldiv_negate #(.W(WIDTH))   u_fix_q (.x(acc[WIDTH-1:0]), .neg(sign_lo_q), .y(quo_fix));
    muldiv_negate #(.W(WIDTH))   u_fix_r (.x(rem[WIDTH-1:0]), .neg(sign_hi_q), .y(rem_fix));

    assign unused_bits = rem[WIDTH];
`else
    assign signed_op = 1'b0;
    assign sign_a    = 1'b0;
    assign sign_b    = 1'b0;
    assign a_mag     = a;
    assign b_mag     = b;
    assign prod_fix  = acc;
    assign quo_fix   = acc[WIDTH-1:0];
    assign rem_fix   = rem[WIDTH-1:0];

    assign unused_bits = ^{rem[WIDTH], signed_op, sign_lo_q, sign_hi_q};
`endif

    // Radix-2 shift-add step; the carry lands in the top bit of the shifted accumulator.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

    // Restoring step: a set top bit of the difference means the trial subtract went negative.
    assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign q_bit     = ~div_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start) next_state = S_ITER;
            S_ITER:  if (cnt == LAST_CNT) next_state = S_FIX;
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            divzero   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            rem       <= '0;
            mcand     <= '0;
            is_div_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            sign_lo_q <= 1'b0;
            sign_hi_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand     <= b_mag;
                        acc       <= {{WIDTH{1'b0}}, a_mag};
                        rem       <= '0;
                        cnt       <= '0;
                        is_div_q  <= is_div_op;
                        b_zero_q  <= (b == '0);
                        sign_lo_q <= sign_a ^ sign_b;
                        sign_hi_q <= is_div_op ? sign_a : (sign_a ^ sign_b);
                        divzero   <= 1'b0;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                S_ITER: begin
                    cnt <= cnt + 1'b1;
                    if (is_div_q) begin
                        rem            <= q_bit ? div_diff : div_shift;
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], q_bit};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    done    <= 1'b1;
                    divzero <= is_div_q & b_zero_q;
                    if (is_div_q) begin
                        // With a zero divisor every quotient bit is 1 and the remainder
                        // ends as |a|, which the dividend-sign fix turns back into raw a.
                        lo <= b_zero_q ? '1 : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit

module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          mthi;
    logic          mtlo;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          divzero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one op and wait at negedges for done; lat counts cycles from the start cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_result(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo, input logic exp_dz);
        int lat, bc;
        run_op(o, x, y, lat, bc);
        check_eq({tag, "_lat"}, 64'(lat), 64'd34);
        check_eq({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        check_eq({tag, "_dz"}, 64'(divzero), 64'(exp_dz));
    endtask

    initial begin
        int lat, bc, ndone, first_done;
        logic [W-1:0] m3;
        logic [W-1:0] m7;
        logic [W-1:0] m5;
        m3 = -32'sd3;
        m7 = -32'sd7;
        m5 = -32'sd5;

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        check_eq("rst_flags", {61'd0, busy, done, divzero}, 64'd0);
        reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        check_eq("multu_lat", 64'(lat), 64'd34);
        check_eq("multu_busy_cycles", 64'(bc), 64'd33);
        check_eq("multu_busy_at_done", 64'(busy), 64'd0);
        check_eq("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        check_eq("done_one_cycle", 64'(done), 64'd0);

`ifdef MULDIV_SIGNED_EN
        op_result("mult_neg", 2'b01, m3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        op_result("div_neg", 2'b11, m7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        op_result("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
`else
        op_result("mult_neg", 2'b01, m3, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        op_result("div_neg", 2'b11, m7, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        op_result("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
`endif
        op_result("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        op_result("divu_zero", 2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        check_eq("divzero_held", 64'(divzero), 64'd1);
        op_result("div_zero_neg", 2'b11, m5, 32'd0, m5, 32'hFFFF_FFFF, 1'b1);

        // Next accepted start clears divzero straight away.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check_eq("divzero_cleared", 64'(divzero), 64'd0);
        ndone = 0; first_done = 0;
        for (int k = 2; k < 70; k++) begin
            if (k == 5) begin
                start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
                mthi = 1'b1; wdata = 32'hAA;
            end
            if (k == 6) begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
        end
        check_eq("ign_start_ndone", 64'(ndone), 64'd1);
        check_eq("ign_start_lat", 64'(first_done), 64'd34);
        check_eq("ign_start_hilo", {hi, lo}, {32'd0, 32'd42});

        mthi = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        mthi = 1'b0;
        check_eq("mthi_idle", {hi, lo}, {32'hAA, 32'd42});
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check_eq("mthi_mtlo", {hi, lo}, {32'h55, 32'h55});

        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check_eq("start_wins_now", {hi, lo}, {32'h55, 32'h55});
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq("start_wins_lat", 64'(lat), 64'd34);
        check_eq("start_wins_hilo", {hi, lo}, {32'd0, 32'd6});

        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("abort_no_done", 64'(ndone), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Sequential multi-cycle multiply/divide unit that owns the HI/LO register pair, replacing the single-cycle combinational multiplier plus hi/lo flops in the datapath. Supports multu/divu, plus mult/div when signed support is compiled in. Also supports mthi/mtlo writes. Sits in the execute stage; the controller stalls on busy, and mfhi/mflo read hi/lo directly.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (must be even and at least 4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  launch operation; sampled only in IDLE
op  in  2  00 multu, 01 mult, 10 divu, 11 div
a  in  WIDTH  multiplicand or dividend (rs)
b  in  WIDTH  multiplier or divisor (rt)
mthi  in  1  write wdata to HI (IDLE only)
mtlo  in  1  write wdata to LO (IDLE only)
wdata  in  WIDTH  data for mthi/mtlo
busy  out  1  high from the edge after start is accepted until the result is written
done  out  1  one-cycle pulse; HI/LO are valid in this cycle
divzero  out  1  high together with done when a divide had b==0; cleared at the next accepted start
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset value of every output and register is 0: hi, lo, busy, done, divzero; state returns to IDLE.
- Reset mid-operation aborts the operation; there is no partial HI/LO update.
- States: IDLE -> ITER (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
- IDLE, start=1: latch the operand magnitudes (abs values if the op is signed), latch the result-sign flags, clear the counter, go to ITER. busy rises at that edge.
- ITER, multiply: radix-2 shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
- ITER, divide: restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits.
- ITER leaves when the counter reaches WIDTH-1.
- FIX: apply the sign correction, then write {hi,lo} at the end of the cycle. In IDLE, done=1 for exactly one cycle and busy=0.
- Latency: start sampled at edge N gives done high in the cycle following edge N+WIDTH+1. That is 34 cycles at WIDTH=32, independent of the operands.
- Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product; signed ops use two's complement.
- Divide result: lo = quotient, hi = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero runs full latency and gives lo = all ones, hi = a (for signed ops, the raw a with no sign fix), divzero=1.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0, divzero=0.
- start while busy: ignored (no queueing).
- mthi/mtlo while busy: ignored.
- start with mthi/mtlo in the same IDLE cycle: start wins and the writes are dropped.
- mthi and mtlo together in IDLE: both registers are written from wdata.
- Operand inputs are don't-care after the start cycle.

Optional Feature:
MULDIV_SIGNED_EN
- Defined: op[0] selects signed. Operands are converted to magnitude on entry and the sign is fixed in FIX.
- Not defined: op[0] is ignored, mult behaves as multu and div behaves as divu. The sign and abs logic is not synthesised, but the FIX cycle remains so latency is identical.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state encoding (S_IDLE, S_ITER, S_FIX), and a localparam helper for CNT_W.
- Sub-module muldiv_negate (parameter W; inputs x and neg; output y = neg ? -x : x). Used for the operand abs step and the result fix; instantiated only under MULDIV_SIGNED_EN.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> done 34 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, busy high for exactly 33 cycles.
- mult (EN defined) a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. With EN undefined, the same stimulus gives hi=0x00000004, lo=0xFFFFFFF1.
- divu a=100, b=7 -> lo=14, hi=2. div (EN) a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- divu a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, divzero=1 with done. The next start clears divzero.
- Second start pulsed 5 cycles into a multiply -> ignored, a single done with the first result. mthi(wdata=0xAA) while busy -> no effect. mthi in IDLE -> hi=0xAA at the next edge.
- reset asserted 10 cycles into a multiply -> at the next edge hi=lo=0, busy=0, and done never pulses.
